// File: rtl/word_stacker.sv
// word_stacker
// Collects four sequential 32-bit words from a valid/ready input stream and
// presents them as one 128-bit block on a valid/ready output stream. A
// single-entry output register lets collection of the next block overlap the
// downstream handshake, so one word per cycle is sustained.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   clr_i               sync clear: drops partial and pending blocks
//   enable_i            low = hold all state, mask both handshakes
//   valid_i/ready_o     input word handshake, word_i [31:0]
//   valid_o/ready_i     output block handshake, word_o [127:0]
//   cnt_o               words held in the current partial block (0..3)
module word_stacker #(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         enable_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [31:0]  word_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] word_o,
  output logic [1:0]   cnt_o
);

  logic [95:0]  coll_q, coll_d;
  logic [1:0]   cnt_q,  cnt_d;
  logic [127:0] out_q,  out_d;
  logic         full_q, full_d;
  logic         acc, take, last;

  // The fourth word can only be taken if the output slot is free or is being
  // drained this cycle; this is the only combinational ready_i -> ready_o path.
  assign ready_o = enable_i & ((cnt_q != 2'd3) | ~full_q | ready_i);
  assign valid_o = enable_i & full_q;
  assign word_o  = full_q ? out_q : '0;
  assign cnt_o   = cnt_q;

  assign acc  = valid_i & ready_o;
  assign take = valid_o & ready_i;
  assign last = acc & (cnt_q == 2'd3);

  always_comb begin
    coll_d = coll_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    full_d = full_q;
    if (last) begin
      // Completing a block overrides a same-cycle take: new block replaces
      // the old one with no bubble.
      out_d  = MSW_FIRST ? {coll_q[31:0], coll_q[63:32], coll_q[95:64], word_i}
                         : {word_i, coll_q[95:64], coll_q[63:32], coll_q[31:0]};
      full_d = 1'b1;
      cnt_d  = 2'd0;
    end else begin
      if (acc) begin
        case (cnt_q)
          2'd0:    coll_d[31:0]  = word_i;
          2'd1:    coll_d[63:32] = word_i;
          default: coll_d[95:64] = word_i;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
      if (take) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      coll_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      full_q <= 1'b0;
    end else if (enable_i) begin
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_word_stacker.sv
// Directed bench for word_stacker. Two instances share all inputs: u_msw
// (MSW_FIRST=1) and u_lsw (MSW_FIRST=0). Inputs change 1ns after the rising
// edge; outputs are checked before the next edge.
module tb_word_stacker;
  logic         clk = 1'b0;
  logic         rst_n, clr, en, vld_i, rdy_i;
  logic [31:0]  wd_i;
  logic         rdy_m, vld_m, rdy_l, vld_l;
  logic [127:0] wd_m, wd_l;
  logic [1:0]   cnt_m, cnt_l;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  word_stacker #(.MSW_FIRST(1'b1)) u_msw (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(en),
    .valid_i(vld_i), .ready_o(rdy_m), .word_i(wd_i),
    .valid_o(vld_m), .ready_i(rdy_i), .word_o(wd_m), .cnt_o(cnt_m));

  word_stacker #(.MSW_FIRST(1'b0)) u_lsw (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(en),
    .valid_i(vld_i), .ready_o(rdy_l), .word_i(wd_i),
    .valid_o(vld_l), .ready_i(rdy_i), .word_o(wd_l), .cnt_o(cnt_l));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] blk;
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; vld_i = 1'b0; rdy_i = 1'b1; wd_i = '0;

    // reset state
    #3;
    chk("rst_ready_en0", rdy_m, 0);
    en = 1'b1; #1;
    chk("rst_ready_en1", rdy_m, 1);
    chk("rst_valid", vld_m, 0);
    chk("rst_word", wd_m, 0);
    chk("rst_cnt", cnt_m, 0);
    #3 rst_n = 1'b1;
    tick();

    // 1/2: basic assembly, both word orders
    vld_i = 1'b1; wd_i = 32'h00112233; tick();
    chk("t1_cnt1", cnt_m, 1);
    wd_i = 32'h44556677; tick();
    chk("t1_cnt2", cnt_m, 2);
    wd_i = 32'h8899AABB; tick();
    chk("t1_cnt3", cnt_m, 3);
    chk("t1_novalid", vld_m, 0);
    wd_i = 32'hCCDDEEFF; tick();
    vld_i = 1'b0; #1;
    chk("t1_cnt0", cnt_m, 0);
    chk("t1_valid", vld_m, 1);
    chk("t1_word_msw", wd_m, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t2_word_lsw", wd_l, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    tick();
    chk("t1_valid_drop", vld_m, 0);
    chk("t1_word_zero", wd_m, 0);

    // 3: backpressure
    rdy_i = 1'b0; vld_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin wd_i = i; tick(); end
    chk("t3_valid", vld_m, 1);
    chk("t3_blk1", wd_m, {32'd1, 32'd2, 32'd3, 32'd4});
    for (int i = 5; i <= 7; i++) begin wd_i = i; tick(); end
    chk("t3_cnt3", cnt_m, 3);
    chk("t3_blk1_held", wd_m, {32'd1, 32'd2, 32'd3, 32'd4});
    wd_i = 32'd8; #1;
    chk("t3_ready_low", rdy_m, 0);
    tick();
    chk("t3_w8_not_taken", cnt_m, 3);
    rdy_i = 1'b1; #1;
    chk("t3_ready_comb", rdy_m, 1);
    tick();
    vld_i = 1'b0; #1;
    chk("t3_valid2", vld_m, 1);
    chk("t3_blk2", wd_m, {32'd5, 32'd6, 32'd7, 32'd8});
    chk("t3_cnt0", cnt_m, 0);
    tick();
    chk("t3_drain", vld_m, 0);

    // 4: throughput, one word per cycle
    vld_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wd_i = 32'h100 + i; #1;
      chk("t4_ready", rdy_m, 1);
      tick();
      if (i % 4 == 3) begin
        blk = {32'h100 + i - 3, 32'h100 + i - 2, 32'h100 + i - 1, 32'h100 + i};
        chk("t4_valid", vld_m, 1);
        chk("t4_block", wd_m, blk);
      end else begin
        chk("t4_gap", vld_m, 0);
      end
    end
    vld_i = 1'b0; tick();
    chk("t4_done", vld_m, 0);

    // 5: enable and clear
    vld_i = 1'b1; wd_i = 32'hA0; tick();
    wd_i = 32'hA1; tick();
    chk("t5_cnt2", cnt_m, 2);
    en = 1'b0; wd_i = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_ready_off", rdy_m, 0);
      tick();
      chk("t5_cnt_hold", cnt_m, 2);
    end
    en = 1'b1; clr = 1'b1; wd_i = 32'hEE; tick();
    clr = 1'b0;
    chk("t5_clr_cnt", cnt_m, 0);
    chk("t5_clr_valid", vld_m, 0);
    rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin wd_i = 32'hC0 + i; tick(); end
    vld_i = 1'b0; #1;
    chk("t5_fresh", wd_m, {32'hC0, 32'hC1, 32'hC2, 32'hC3});
    en = 1'b0; #1;
    chk("t5_mask_valid", vld_m, 0);
    tick();
    en = 1'b1; #1;
    chk("t5_valid_back", vld_m, 1);
    chk("t5_block_back", wd_m, {32'hC0, 32'hC1, 32'hC2, 32'hC3});
    rdy_i = 1'b1; tick();
    chk("t5_taken", vld_m, 0);

    // 6: asynchronous reset mid-block
    rdy_i = 1'b0; vld_i = 1'b1;
    for (int i = 0; i < 7; i++) begin wd_i = 32'hD0 + i; tick(); end
    vld_i = 1'b0; #1;
    chk("t6_pre_cnt", cnt_m, 3);
    chk("t6_pre_valid", vld_m, 1);
    #1 rst_n = 1'b0; #1;
    chk("t6_valid", vld_m, 0);
    chk("t6_word", wd_m, 0);
    chk("t6_cnt", cnt_m, 0);
    #2 rst_n = 1'b1;
    rdy_i = 1'b1; tick();
    vld_i = 1'b1;
    for (int i = 0; i < 4; i++) begin wd_i = 32'hF0 + i; tick(); end
    vld_i = 1'b0; #1;
    chk("t6_after_valid", vld_m, 1);
    chk("t6_after_block", wd_m, {32'hF0, 32'hF1, 32'hF2, 32'hF3});
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
